// File: rtl/dmem_arbiter.sv
// Arbiter for the single-port data memory shared by the load unit and the store drain.
// Adds a load-streak cap, a store-drain fence, and bounds checking on every access.
module dmem_arbiter #(
    parameter int unsigned MEM_SIZE        = 256,
    parameter int unsigned TAG_W           = 4,
    parameter int unsigned MAX_LOAD_STREAK = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ld_valid_i,
    output logic             ld_ready_o,
    input  logic [31:0]      ld_addr_i,
    input  logic [TAG_W-1:0] ld_tag_i,
    output logic             ld_resp_valid_o,
    output logic [31:0]      ld_resp_data_o,
    output logic [TAG_W-1:0] ld_resp_tag_o,
    output logic             ld_resp_err_o,
    input  logic             st_valid_i,
    output logic             st_ready_o,
    input  logic [31:0]      st_addr_i,
    input  logic [31:0]      st_data_i,
    output logic             st_err_o,
    input  logic             sb_empty_i,
    input  logic             fence_i,
    output logic             fence_done_o,
    output logic             mem_wr_en_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_o,
    input  logic [31:0]      mem_data_i
);

    localparam int unsigned STREAK_W  = $clog2(MAX_LOAD_STREAK + 1);
    localparam logic [31:0] LAST_ADDR = 32'(MEM_SIZE - 4);

    typedef enum logic {
        ST_NORMAL,
        ST_FENCE
    } state_e;

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [TAG_W-1:0]    resp_tag_q, resp_tag_d;
    logic                resp_err_q, resp_err_d;
    logic                st_err_q, st_err_d;
    logic                fence_done_q, fence_done_d;

    logic ld_grant, st_grant;
    logic ld_oob, st_oob;

    // Comparing against the last legal word start avoids the addr+3 overflow.
    assign ld_oob = ld_addr_i > LAST_ADDR;
    assign st_oob = st_addr_i > LAST_ADDR;

    always_comb begin
        ld_grant     = 1'b0;
        st_grant     = 1'b0;
        state_d      = state_q;
        fence_done_d = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                ld_grant = ld_valid_i &&
                           (!st_valid_i || streak_q < STREAK_W'(MAX_LOAD_STREAK));
                st_grant = st_valid_i && !ld_grant;
                if (fence_i) begin
                    state_d = ST_FENCE;
                end
            end
            ST_FENCE: begin
                st_grant = st_valid_i;
                if (sb_empty_i && !st_valid_i) begin
                    state_d      = ST_NORMAL;
                    fence_done_d = 1'b1;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_comb begin
        streak_d = streak_q;
        if (st_grant || !st_valid_i) begin
            streak_d = '0;
        end else if (ld_grant) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_comb begin
        mem_wr_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        if (ld_grant && !ld_oob) begin
            mem_addr_o = ld_addr_i;
        end else if (st_grant && !st_oob) begin
            mem_wr_en_o = 1'b1;
            mem_addr_o  = st_addr_i;
            mem_data_o  = st_data_i;
        end
    end

    // Data and tag hold their last value between responses.
    always_comb begin
        resp_valid_d = ld_grant;
        resp_err_d   = ld_grant && ld_oob;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;
        if (ld_grant) begin
            resp_data_d = ld_oob ? 32'h0 : mem_data_i;
            resp_tag_d  = ld_tag_i;
        end
        st_err_d = st_grant && st_oob;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_NORMAL;
            streak_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
            resp_err_q   <= 1'b0;
            st_err_q     <= 1'b0;
            fence_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
            resp_err_q   <= resp_err_d;
            st_err_q     <= st_err_d;
            fence_done_q <= fence_done_d;
        end
    end

    assign ld_ready_o      = ld_grant;
    assign st_ready_o      = st_grant;
    assign ld_resp_valid_o = resp_valid_q;
    assign ld_resp_data_o  = resp_data_q;
    assign ld_resp_tag_o   = resp_tag_q;
    assign ld_resp_err_o   = resp_err_q;
    assign st_err_o        = st_err_q;
    assign fence_done_o    = fence_done_q;

endmodule
